cam_req_sequencer: RTL and testbench

- Upstream front-end for the cam block.
- Accepts read/write/search commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the CAM as a single-cycle enable pulse.
- Captures the CAM result after a fixed latency and returns it on a valid/ready response channel, holding it until the consumer accepts it.

---
 rtl/cam_req_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_cam_req_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_req_sequencer.sv
`default_nettype none
// cam_req_sequencer: command FIFO plus one-at-a-time issue FSM in front of the CAM; rev 1.0
// Each command becomes a single-cycle CAM enable; the result is held on a valid/ready response port.
module cam_req_sequencer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4,
  parameter int CAM_LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_index_i,
  input  logic [WIDTH-1:0]      cmd_data_i,
  output logic                  cam_read_enable_o,
  output logic [ADDR_WIDTH-1:0] cam_read_index_o,
  output logic                  cam_write_enable_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [WIDTH-1:0]      cam_write_data_o,
  output logic                  cam_search_enable_o,
  output logic [WIDTH-1:0]      cam_search_data_o,
  input  logic                  cam_read_valid_i,
  input  logic [WIDTH-1:0]      cam_read_value_i,
  input  logic                  cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_op_o,
  output logic                  rsp_hit_o,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  logic [1:0]            op_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] idx_mem  [DEPTH];
  logic [WIDTH-1:0]      data_mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  state_e                state_q;
  logic [LW-1:0]         wait_q;
  logic [1:0]            cur_op_q;
  logic [ADDR_WIDTH-1:0] cur_idx_q;
  logic [WIDTH-1:0]      cur_data_q;

  logic                  rd_en_q, wr_en_q, sr_en_q;
  logic [ADDR_WIDTH-1:0] rd_idx_q, wr_idx_q;
  logic [WIDTH-1:0]      wr_data_q, sr_data_q;

  logic                  rsp_valid_q, rsp_hit_q;
  logic [1:0]            rsp_op_q;
  logic [WIDTH-1:0]      rsp_data_q;
  logic [ADDR_WIDTH-1:0] rsp_idx_q;

  logic                  push, pop;
  logic [1:0]            head_op;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic [WIDTH-1:0]      head_data;

  assign cmd_ready_o = (count_q < CW'(DEPTH));
  assign push        = cmd_valid_i & cmd_ready_o;
  assign pop         = (state_q == S_IDLE) && (count_q != '0);
  assign head_op     = op_mem[rd_ptr_q];
  assign head_idx    = idx_mem[rd_ptr_q];
  assign head_data   = data_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem[wr_ptr_q]   <= cmd_op_i;
      idx_mem[wr_ptr_q]  <= cmd_index_i;
      data_mem[wr_ptr_q] <= cmd_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      wait_q      <= '0;
      cur_op_q    <= '0;
      cur_idx_q   <= '0;
      cur_data_q  <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      sr_en_q     <= 1'b0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      sr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_idx_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_op_q   <= head_op;
            cur_idx_q  <= head_idx;
            cur_data_q <= head_data;
            rd_idx_q   <= head_idx;
            wr_idx_q   <= head_idx;
            wr_data_q  <= head_data;
            sr_data_q  <= head_data;
            case (head_op)
              OP_READ: begin
                rd_en_q <= 1'b1;
                state_q <= S_ISSUE;
              end
              OP_WRITE: begin
                wr_en_q <= 1'b1;
                state_q <= S_ISSUE;
              end
              OP_SEARCH: begin
                sr_en_q <= 1'b1;
                state_q <= S_ISSUE;
              end
              default: begin
                // Reserved opcode never touches the CAM; answer with a miss.
                rsp_valid_q <= 1'b1;
                rsp_op_q    <= head_op;
                rsp_hit_q   <= 1'b0;
                rsp_data_q  <= head_data;
                rsp_idx_q   <= head_idx;
                state_q     <= S_RESP;
              end
            endcase
          end
        end
        S_ISSUE: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          sr_en_q <= 1'b0;
          wait_q  <= LW'(CAM_LAT - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_op_q    <= cur_op_q;
            state_q     <= S_RESP;
            case (cur_op_q)
              OP_READ: begin
                rsp_hit_q  <= cam_read_valid_i;
                rsp_data_q <= cam_read_value_i;
                rsp_idx_q  <= cur_idx_q;
              end
              OP_SEARCH: begin
                rsp_hit_q  <= cam_search_valid_i;
                rsp_data_q <= cur_data_q;
                rsp_idx_q  <= cam_search_valid_i ? cam_search_index_i : '0;
              end
              default: begin
                rsp_hit_q  <= 1'b1;
                rsp_data_q <= cur_data_q;
                rsp_idx_q  <= cur_idx_q;
              end
            endcase
          end else begin
            wait_q <= wait_q - LW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cam_read_enable_o   = rd_en_q;
  assign cam_read_index_o    = rd_idx_q;
  assign cam_write_enable_o  = wr_en_q;
  assign cam_write_index_o   = wr_idx_q;
  assign cam_write_data_o    = wr_data_q;
  assign cam_search_enable_o = sr_en_q;
  assign cam_search_data_o   = sr_data_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_op_o            = rsp_op_q;
  assign rsp_hit_o           = rsp_hit_q;
  assign rsp_data_o          = rsp_data_q;
  assign rsp_index_o         = rsp_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_req_sequencer.sv
`default_nettype none
// tb_cam_req_sequencer: directed tests of cam_req_sequencer against small CAM models
// (latency 1 and latency 3 instances).
module tb_cam_req_sequencer;
  localparam int W  = 32;
  localparam int AW = 5;

  int checks = 0;
  int fails  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // latency-1 instance
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op    = '0;
  logic [AW-1:0] cmd_index = '0;
  logic [W-1:0]  cmd_data  = '0;
  logic          rd_en, wr_en, sr_en;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [W-1:0]  wr_data, sr_data;
  logic          m_rd_valid = 1'b0;
  logic [W-1:0]  m_rd_value = '0;
  logic          m_sr_valid = 1'b0;
  logic [AW-1:0] m_sr_index = '0;
  logic          rsp_valid, rsp_hit;
  logic          rsp_ready = 1'b1;
  logic [1:0]    rsp_op;
  logic [W-1:0]  rsp_data;
  logic [AW-1:0] rsp_index;

  // latency-3 instance (shares the command payload inputs)
  logic          cmd_valid3 = 1'b0;
  logic          cmd_ready3;
  logic          rd_en3, wr_en3, sr_en3;
  logic [AW-1:0] rd_idx3, wr_idx3;
  logic [W-1:0]  wr_data3, sr_data3;
  logic [2:0]    pipe3 = '0;
  logic          rsp_valid3, rsp_hit3;
  logic          rsp_ready3 = 1'b1;
  logic [1:0]    rsp_op3;
  logic [W-1:0]  rsp_data3;
  logic [AW-1:0] rsp_index3;

  cam_req_sequencer #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(4), .CAM_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .cam_read_enable_o(rd_en), .cam_read_index_o(rd_idx),
    .cam_write_enable_o(wr_en), .cam_write_index_o(wr_idx), .cam_write_data_o(wr_data),
    .cam_search_enable_o(sr_en), .cam_search_data_o(sr_data),
    .cam_read_valid_i(m_rd_valid), .cam_read_value_i(m_rd_value),
    .cam_search_valid_i(m_sr_valid), .cam_search_index_i(m_sr_index),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_op_o(rsp_op),
    .rsp_hit_o(rsp_hit), .rsp_data_o(rsp_data), .rsp_index_o(rsp_index)
  );

  cam_req_sequencer #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(4), .CAM_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n),
    .cmd_valid_i(cmd_valid3), .cmd_ready_o(cmd_ready3), .cmd_op_i(cmd_op),
    .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .cam_read_enable_o(rd_en3), .cam_read_index_o(rd_idx3),
    .cam_write_enable_o(wr_en3), .cam_write_index_o(wr_idx3), .cam_write_data_o(wr_data3),
    .cam_search_enable_o(sr_en3), .cam_search_data_o(sr_data3),
    .cam_read_valid_i(pipe3[2]), .cam_read_value_i(pipe3[2] ? 32'hDEAD_BEEF : 32'h0),
    .cam_search_valid_i(1'b0), .cam_search_index_i(5'd0),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_op_o(rsp_op3),
    .rsp_hit_o(rsp_hit3), .rsp_data_o(rsp_data3), .rsp_index_o(rsp_index3)
  );

  // Latency-1 CAM model: result is registered at the edge closing the enable cycle.
  logic [W-1:0]  mem1 [32];
  logic [31:0]   mv1 = '0;
  logic          s_found;
  logic [AW-1:0] s_idx;

  always_comb begin
    s_found = 1'b0;
    s_idx   = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mv1[i] && mem1[i] == sr_data) begin
        s_found = 1'b1;
        s_idx   = AW'(i);
      end
    end
  end

  always @(posedge clk) begin
    m_rd_valid <= rd_en & mv1[rd_idx];
    m_rd_value <= rd_en ? mem1[rd_idx] : '0;
    m_sr_valid <= sr_en & s_found;
    m_sr_index <= (sr_en & s_found) ? s_idx : '0;
    if (wr_en) begin
      mem1[wr_idx] <= wr_data;
      mv1[wr_idx]  <= 1'b1;
    end
  end

  // Latency-3 CAM model: entry 3 holds 0xDEADBEEF; valid lasts exactly one cycle.
  always @(posedge clk) pipe3 <= {pipe3[1:0], rd_en3 && (rd_idx3 == 5'd3)};

  int            n_rd = 0, n_wr = 0, n_sr = 0, n_multi = 0, n_rspv = 0, n_en3 = 0;
  logic [AW-1:0] last_wr_idx = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) n_rd <= n_rd + 1;
      if (wr_en) begin
        n_wr        <= n_wr + 1;
        last_wr_idx <= wr_idx;
      end
      if (sr_en) n_sr <= n_sr + 1;
      if ((int'(rd_en) + int'(wr_en) + int'(sr_en)) > 1) n_multi <= n_multi + 1;
      if (rsp_valid) n_rspv <= n_rspv + 1;
      if (rd_en3 || wr_en3 || sr_en3) n_en3 <= n_en3 + 1;
    end
  end

  task automatic try_push(input logic [1:0] op, input logic [AW-1:0] idx,
                          input logic [W-1:0] d, output bit acc);
    cmd_op    = op;
    cmd_index = idx;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Counts edges until rsp_valid is seen; a missing response is a failed comparison.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (!rsp_valid) begin
      fails++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d edges, required 1", rsp_valid, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if ({rd_en, wr_en, sr_en} !== 3'b000) begin fails++; $display("FAIL reset_enables: got %b want 000", {rd_en, wr_en, sr_en}); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_op, rsp_hit, rsp_index, rsp_data} !== '0) begin fails++; $display("FAIL reset_rsp_payload: got op=%b hit=%b idx=%0d data=%h want 0", rsp_op, rsp_hit, rsp_index, rsp_data); end
    checks++; if ({rd_idx, wr_idx, wr_data, sr_data} !== '0) begin fails++; $display("FAIL reset_cam_payload: got rd_idx=%0d wr_idx=%0d wr_data=%h sr_data=%h want 0", rd_idx, wr_idx, wr_data, sr_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    int lat;
    bit acc;
    int wr0 = n_wr, rd0 = n_rd, sr0 = n_sr;
    rsp_ready = 1'b1;
    try_push(2'b01, 5'd3, 32'hDEAD_BEEF, acc);
    checks++; if (acc !== 1'b1) begin fails++; $display("FAIL write_accept: got %b want 1", acc); end
    wait_valid(lat);
    checks++; if (lat != 3) begin fails++; $display("FAIL write_latency: got %0d edges want 3", lat); end
    checks++; if ({rsp_op, rsp_hit, rsp_index, rsp_data} !== {2'b01, 1'b1, 5'd3, 32'hDEAD_BEEF}) begin fails++; $display("FAIL write_rsp: got op=%b hit=%b idx=%0d data=%h want op=01 hit=1 idx=3 data=deadbeef", rsp_op, rsp_hit, rsp_index, rsp_data); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL write_rsp_consumed: got %b want 0", rsp_valid); end
    checks++; if ((n_wr - wr0) != 1 || last_wr_idx !== 5'd3) begin fails++; $display("FAIL write_enable_pulse: got %0d cycles idx=%0d want 1 cycle idx=3", n_wr - wr0, last_wr_idx); end
    checks++; if ((n_rd - rd0) != 0 || (n_sr - sr0) != 0) begin fails++; $display("FAIL write_other_enables: got rd=%0d sr=%0d want 0", n_rd - rd0, n_sr - sr0); end
  endtask

  task automatic test_search_read();
    int lat;
    bit acc;
    rsp_ready = 1'b1;
    try_push(2'b10, 5'd0, 32'hDEAD_BEEF, acc);
    wait_valid(lat);
    checks++; if ({rsp_op, rsp_hit, rsp_index, rsp_data} !== {2'b10, 1'b1, 5'd3, 32'hDEAD_BEEF}) begin fails++; $display("FAIL search_hit: got op=%b hit=%b idx=%0d data=%h want op=10 hit=1 idx=3 data=deadbeef", rsp_op, rsp_hit, rsp_index, rsp_data); end
    @(posedge clk); #1;
    try_push(2'b10, 5'd9, 32'h1234_5678, acc);
    wait_valid(lat);
    checks++; if ({rsp_op, rsp_hit, rsp_index, rsp_data} !== {2'b10, 1'b0, 5'd0, 32'h1234_5678}) begin fails++; $display("FAIL search_miss: got op=%b hit=%b idx=%0d data=%h want op=10 hit=0 idx=0 data=12345678", rsp_op, rsp_hit, rsp_index, rsp_data); end
    @(posedge clk); #1;
    try_push(2'b00, 5'd3, 32'h0, acc);
    wait_valid(lat);
    checks++; if (lat != 3) begin fails++; $display("FAIL read_latency: got %0d edges want 3", lat); end
    checks++; if ({rsp_op, rsp_hit, rsp_index, rsp_data} !== {2'b00, 1'b1, 5'd3, 32'hDEAD_BEEF}) begin fails++; $display("FAIL read_rsp: got op=%b hit=%b idx=%0d data=%h want op=00 hit=1 idx=3 data=deadbeef", rsp_op, rsp_hit, rsp_index, rsp_data); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reserved();
    int lat;
    bit acc;
    int en0 = n_rd + n_wr + n_sr;
    rsp_ready = 1'b1;
    try_push(2'b11, 5'd7, 32'hA5A5_A5A5, acc);
    wait_valid(lat);
    // Reserved ops skip ISSUE/WAIT: response is up right after the popping edge.
    checks++; if (lat != 1) begin fails++; $display("FAIL reserved_latency: got %0d edges want 1", lat); end
    checks++; if ({rsp_op, rsp_hit, rsp_index, rsp_data} !== {2'b11, 1'b0, 5'd7, 32'hA5A5_A5A5}) begin fails++; $display("FAIL reserved_rsp: got op=%b hit=%b idx=%0d data=%h want op=11 hit=0 idx=7 data=a5a5a5a5", rsp_op, rsp_hit, rsp_index, rsp_data); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if ((n_rd + n_wr + n_sr) != en0) begin fails++; $display("FAIL reserved_no_enable: got %0d enable cycles want 0", n_rd + n_wr + n_sr - en0); end
  endtask

  task automatic test_backpressure();
    int lat;
    bit acc;
    int n_acc = 0;
    rsp_ready = 1'b0;
    // One command goes in flight and four queue behind it before ready drops.
    for (int i = 0; i < 6; i++) begin
      try_push(2'b01, AW'(10 + i), 32'h1000_0000 + i, acc);
      if (acc) n_acc++;
    end
    checks++; if (n_acc != 5) begin fails++; $display("FAIL bp_accepted: got %0d want 5", n_acc); end
    checks++; if (acc !== 1'b0 || cmd_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low: got last_acc=%b ready=%b want 0 0", acc, cmd_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++; if ({rsp_valid, rsp_op, rsp_hit, rsp_index, rsp_data} !== {1'b1, 2'b01, 1'b1, 5'd10, 32'h1000_0000}) begin fails++; $display("FAIL bp_hold: cycle %0d got v=%b op=%b idx=%0d data=%h want v=1 op=01 idx=10 data=10000000", k, rsp_valid, rsp_op, rsp_index, rsp_data); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_valid(lat);
      checks++; if ({rsp_op, rsp_hit, rsp_index, rsp_data} !== {2'b01, 1'b1, AW'(10 + j), 32'h1000_0000 + j}) begin fails++; $display("FAIL bp_order: rsp %0d got op=%b hit=%b idx=%0d data=%h want idx=%0d", j, rsp_op, rsp_hit, rsp_index, rsp_data, 10 + j); end
      @(posedge clk); #1;
    end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back: got %b want 1", cmd_ready); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit acc;
    int rsp0, en0;
    rsp_ready = 1'b1;
    try_push(2'b00, 5'd3, 32'h0, acc);
    try_push(2'b10, 5'd0, 32'hDEAD_BEEF, acc);
    try_push(2'b01, 5'd20, 32'h0000_0055, acc);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({rd_en, wr_en, sr_en, rsp_valid} !== 4'b0000) begin fails++; $display("FAIL midrst_wait: got en=%b rsp_valid=%b want 000 0", {rd_en, wr_en, sr_en}, rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp0 = n_rspv;
    en0  = n_rd + n_wr + n_sr;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (n_rspv != rsp0 || (n_rd + n_wr + n_sr) != en0) begin fails++; $display("FAIL midrst_discard: got rsp_cycles=%0d enable_cycles=%0d want 0 0", n_rspv - rsp0, n_rd + n_wr + n_sr - en0); end
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end

    try_push(2'b00, 5'd3, 32'h0, acc);
    @(posedge clk); #1;
    checks++; if (rd_en !== 1'b1) begin fails++; $display("FAIL midrst_issue: got rd_en=%b want 1", rd_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b0) begin fails++; $display("FAIL midrst_enable_async: got rd_en=%b want 0", rd_en); end
    @(negedge clk);
    rst_n = 1'b1;

    rsp_ready = 1'b0;
    try_push(2'b01, 5'd5, 32'h0BAD_F00D, acc);
    wait_valid(lat);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin fails++; $display("FAIL midrst_rsp_async: got v=%b data=%h want 0 0", rsp_valid, rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_lat3();
    int lat = 0;
    int e0 = n_en3;
    cmd_op     = 2'b00;
    cmd_index  = 5'd3;
    cmd_data   = 32'h0;
    cmd_valid3 = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready3 !== 1'b1) begin fails++; $display("FAIL lat3_ready: got %b want 1", cmd_ready3); end
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    while (!rsp_valid3 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 5) begin fails++; $display("FAIL lat3_latency: got %0d edges want 5", lat); end
    checks++; if ({rsp_valid3, rsp_op3, rsp_hit3, rsp_index3, rsp_data3} !== {1'b1, 2'b00, 1'b1, 5'd3, 32'hDEAD_BEEF}) begin fails++; $display("FAIL lat3_rsp: got v=%b op=%b hit=%b idx=%0d data=%h want v=1 op=00 hit=1 idx=3 data=deadbeef", rsp_valid3, rsp_op3, rsp_hit3, rsp_index3, rsp_data3); end
    checks++; if ((n_en3 - e0) != 1) begin fails++; $display("FAIL lat3_enable_pulse: got %0d cycles want 1", n_en3 - e0); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_search_read();
    test_reserved();
    test_backpressure();
    test_reset_mid();
    test_lat3();
    checks++; if (n_multi != 0) begin fails++; $display("FAIL one_enable_per_cycle: got %0d overlapping cycles want 0", n_multi); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
